// File: rtl/cp0_bus_arbiter.sv
// Round-robin arbiter for the shared, tri-stated CP0 read-data bus.
// Each grant drives the bus for at most HOLD_CYCLES. Every grant is followed by
// TURN_CYCLES of bus float, so two bank drivers never overlap.
// All outputs come from flops, so there is no combinational path from req to gnt.
module cp0_bus_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    grant_id,
    output logic               bus_busy,
    output logic               xfer_done,
    output logic               xfer_abort
);

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    localparam logic [CNT_W-1:0]   HoldInit = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TurnInit = CNT_W'(TURN_CYCLES - 1);
    localparam logic [ID_W-1:0]    LastId   = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] OneHot0  = NUM_REQ'(1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;

    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic                 owner_req;

    // Winner is the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign owner_req = req[grant_id_q];

    // Next-state logic for the IDLE / GRANT / TURN sequencer and its registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        grant_id_d = grant_id_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d    = StGrant;
                    gnt_d      = OneHot0 << win_id;
                    grant_id_d = win_id;
                    cnt_d      = HoldInit;
                end
            end
            StGrant: begin
                if (cnt_q == '0 || !owner_req) begin
                    // The grantee drops to lowest priority for the next arbitration.
                    state_d  = StTurn;
                    gnt_d    = '0;
                    rr_ptr_d = (grant_id_q == LastId) ? '0 : grant_id_q + 1'b1;
                    cnt_d    = TurnInit;
                    done_d   = owner_req;
                    abort_d  = !owner_req;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTurn: begin
                gnt_d = '0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (win_found) begin
                    state_d    = StGrant;
                    gnt_d      = OneHot0 << win_id;
                    grant_id_d = win_id;
                    cnt_d      = HoldInit;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; async reset drops gnt without waiting for a clock.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign gnt        = gnt_q;
    assign grant_id   = grant_id_q;
    assign bus_busy   = busy_q;
    assign xfer_done  = done_q;
    assign xfer_abort = abort_q;

endmodule

// File: tb/tb_cp0_bus_arbiter.sv
// Self-checking bench for cp0_bus_arbiter: directed scenarios plus randomized
// traffic compared against a grant-level reference model.
module tb_cp0_bus_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 2;
    localparam int TURN = 1;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] req_b = '0;
    logic [3:0] gnt, gnt_b;
    logic [1:0] grant_id, grant_id_b;
    logic       bus_busy, bus_busy_b;
    logic       xfer_done, xfer_done_b;
    logic       xfer_abort, xfer_abort_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_bus_arbiter #(
        .NUM_REQ(4), .ID_W(2), .HOLD_CYCLES(2), .TURN_CYCLES(1), .CNT_W(4)
    ) dut (
        .clk(clk), .reset_l(reset_l), .req(req), .gnt(gnt), .grant_id(grant_id),
        .bus_busy(bus_busy), .xfer_done(xfer_done), .xfer_abort(xfer_abort)
    );

    cp0_bus_arbiter #(
        .NUM_REQ(4), .ID_W(2), .HOLD_CYCLES(1), .TURN_CYCLES(3), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset_l(reset_l), .req(req_b), .gnt(gnt_b), .grant_id(grant_id_b),
        .bus_busy(bus_busy_b), .xfer_done(xfer_done_b), .xfer_abort(xfer_abort_b)
    );

    // Bus-safety invariants on both instances, every cycle out of reset.
    always @(negedge clk) begin
        if (reset_l) begin
            checks++;
            if (!$onehot0(gnt) || !$onehot0(gnt_b)) begin
                errors++;
                $display("FAIL onehot0 gnt=%b gnt_b=%b", gnt, gnt_b);
            end
            checks++;
            if ((xfer_done && xfer_abort) || (xfer_done_b && xfer_abort_b)) begin
                errors++;
                $display("FAIL pulse_excl a=%b%b b=%b%b", xfer_done, xfer_abort,
                         xfer_done_b, xfer_abort_b);
            end
        end
    end

    // ---------------- reference model (grant/transaction level) ----------------
    int m_owner;   // current grantee, -1 when nobody drives
    int m_age;     // cycles the current grantee has driven so far
    int m_gap;     // float cycles elapsed since the last grant ended, 0 when idle
    int m_ptr;     // first index scanned at the next arbitration
    int m_last;    // last grantee
    bit m_done, m_abort;

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_gap = 0; m_ptr = 0; m_last = 0;
        m_done = 0; m_abort = 0;
    endtask

    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (((r >> i) & 4'd1) != 4'd0) return i;
        end
        return -1;
    endfunction

    // Advance the model across one rising edge that samples r.
    task automatic model_step(input logic [3:0] r);
        bit held;
        int w;
        m_done = 0;
        m_abort = 0;
        if (m_owner >= 0) begin
            held = (((r >> m_owner) & 4'd1) != 4'd0);
            if (m_age == HOLD || !held) begin
                m_done  = held;
                m_abort = !held;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_age++;
            end
        end else if (m_gap > 0 && m_gap < TURN) begin
            m_gap++;
        end else begin
            w = pick(r, m_ptr);
            m_gap = 0;
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_age   = 1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic do_reset();
        reset_l = 1'b0;
        req     = '0;
        req_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_l = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_l = 1'b0;
        req     = 4'b1111;
        step();
        checks++;
        if (gnt !== 4'b0000 || bus_busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state gnt=%b busy=%b id=%0d want 0000/0/0", gnt, bus_busy, grant_id);
        end
        checks++;
        if (xfer_done !== 1'b0 || xfer_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses done=%b abort=%b want 0/0", xfer_done, xfer_abort);
        end
        @(negedge clk);
        reset_l = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001 || grant_id !== 2'd0 || bus_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant gnt=%b id=%0d busy=%b want 0001/0/1",
                     gnt, grant_id, bus_busy);
        end
        req = '0;
    endtask

    task automatic test_sole_requester();
        logic [3:0] eg [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
        logic       ed [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (gnt !== eg[c] || xfer_done !== ed[c] || xfer_abort !== 1'b0) begin
                errors++;
                $display("FAIL sole_req cyc%0d gnt=%b done=%b abort=%b want %b/%b/0",
                         c + 1, gnt, xfer_done, xfer_abort, eg[c], ed[c]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 14; c++) begin
            int k, ph;
            k  = (c - 1) / 3;
            ph = (c - 1) % 3;
            exp_g = (ph < 2) ? 4'(1 << (k % N)) : 4'b0000;
            step();
            checks++;
            if (gnt !== exp_g || (ph < 2 && grant_id !== 2'(k % N))) begin
                errors++;
                $display("FAIL round_robin cyc%0d gnt=%b id=%0d want gnt=%b id=%0d",
                         c, gnt, grant_id, exp_g, k % N);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0010;
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL abort_grant gnt=%b want 0010", gnt);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || xfer_abort !== 1'b1 || xfer_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse gnt=%b abort=%b done=%b want 0000/1/0",
                     gnt, xfer_abort, xfer_done);
        end
        step();
        checks++;
        if (xfer_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_one_cycle abort=%b want 0", xfer_abort);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1111;
        repeat (10) step();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL async_pre gnt=%b want 1000", gnt);
        end
        #2;
        reset_l = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || bus_busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL async_clear gnt=%b busy=%b id=%0d want 0000/0/0", gnt, bus_busy, grant_id);
        end
        checks++;
        if (xfer_done !== 1'b0 || xfer_abort !== 1'b0) begin
            errors++;
            $display("FAIL async_pulses done=%b abort=%b want 0/0", xfer_done, xfer_abort);
        end
        #2;
        reset_l = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001 || grant_id !== 2'd0 || xfer_done !== 1'b0 || xfer_abort !== 1'b0) begin
            errors++;
            $display("FAIL async_regrant gnt=%b id=%0d done=%b abort=%b want 0001/0/0/0",
                     gnt, grant_id, xfer_done, xfer_abort);
        end
    endtask

    task automatic test_hold1_turn3();
        logic [3:0] exp_g;
        do_reset();
        req_b = 4'b0011;
        for (int c = 1; c <= 9; c++) begin
            int k, ph;
            k  = (c - 1) / 4;
            ph = (c - 1) % 4;
            exp_g = (ph == 0) ? 4'(1 << (k % 2)) : 4'b0000;
            step();
            checks++;
            if (gnt_b !== exp_g) begin
                errors++;
                $display("FAIL hold1_turn3 cyc%0d gnt=%b want %b", c, gnt_b, exp_g);
            end
        end
        req_b = '0;
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(19) == 0) begin
                req = '0;
            end else begin
                for (int b = 0; b < N; b++) begin
                    if (req[b]) begin
                        if ($urandom_range(7) == 0) req[b] = 1'b0;
                    end else begin
                        if ($urandom_range(3) == 0) req[b] = 1'b1;
                    end
                end
            end
            @(posedge clk);
            model_step(req);
            #1;
            exp_g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("FAIL rand_gnt cyc%0d gnt=%b want %b", c, gnt, exp_g);
            end
            checks++;
            if (grant_id !== 2'(m_last)) begin
                errors++;
                $display("FAIL rand_id cyc%0d id=%0d want %0d", c, grant_id, m_last);
            end
            checks++;
            if (xfer_done !== m_done || xfer_abort !== m_abort) begin
                errors++;
                $display("FAIL rand_pulse cyc%0d done=%b abort=%b want %b/%b",
                         c, xfer_done, xfer_abort, m_done, m_abort);
            end
            checks++;
            if (bus_busy !== (m_owner >= 0 || m_gap > 0)) begin
                errors++;
                $display("FAIL rand_busy cyc%0d busy=%b want %b", c, bus_busy,
                         (m_owner >= 0 || m_gap > 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sole_requester();
        test_round_robin();
        test_abort();
        test_async_reset();
        test_hold1_turn3();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
